// File: rtl/uart_reg_master.sv
// uart_reg_master: serial register-bank initiator sending 8N1 command/data frames and capturing one-byte read replies.
module uart_reg_master #(
  parameter int CLKS_PER_BIT = 142,
  parameter int TIMEOUT_CLKS = 4096
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [2:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       busy_out,
  output logic       tx_out,
  input  logic       rx_in
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  typedef enum logic [2:0] {IDLE, TX_CMD, TX_DATA, RX_WAIT, RX_DATA, RESP} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [TW-1:0] tmo_q;
  logic [3:0]    bit_q;
  logic [2:0]    addr_q;
  logic [7:0]    wdata_q, rx_byte_q, rsp_rdata_q;
  logic          write_q, tx_q, rx_s1_q, rx_s2_q, qual_q, rsp_valid_q, rsp_err_q;
  logic [9:0]    frame_d;
  logic          bit_end_d, half_d;
  always_comb begin
    frame_d   = {1'b1, state_q == TX_CMD ? {~write_q, 4'b0000, addr_q} : wdata_q, 1'b0};
    bit_end_d = cnt_q == CW'(CLKS_PER_BIT - 1);
    half_d    = cnt_q == CW'(CLKS_PER_BIT / 2 - 1);
  end
  always_ff @(posedge clk_in) begin
    rx_s1_q <= rx_in;
    rx_s2_q <= rx_s1_q;
    if (rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      bit_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rx_byte_q   <= '0;
      write_q     <= 1'b0;
      qual_q      <= 1'b0;
      tx_q        <= 1'b1;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          state_q <= TX_CMD;
          write_q <= req_write;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          tx_q    <= 1'b0;
          cnt_q   <= '0;
          bit_q   <= '0;
        end
        TX_CMD, TX_DATA: if (!bit_end_d) cnt_q <= cnt_q + 1'b1;
        else begin
          cnt_q <= '0;
          if (bit_q != 4'd9) begin
            bit_q <= bit_q + 1'b1;
            tx_q  <= frame_d[bit_q + 4'd1];
          end else if (state_q == TX_CMD && write_q) begin
            state_q <= TX_DATA;
            bit_q   <= '0;
            tx_q    <= 1'b0;
          end else if (state_q == TX_CMD) begin
            state_q <= RX_WAIT;
            tmo_q   <= '0;
            qual_q  <= 1'b0;
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        RX_WAIT: begin
          tmo_q <= tmo_q + 1'b1;
          // a start qualified on the final timeout cycle still wins
          if (qual_q && half_d && !rx_s2_q) begin
            state_q <= RX_DATA;
            cnt_q   <= '0;
            bit_q   <= '0;
          end else if (tmo_q == TW'(TIMEOUT_CLKS - 1)) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
          end else if (qual_q) begin
            cnt_q  <= cnt_q + 1'b1;
            qual_q <= !half_d;
          end else if (!rx_s2_q) begin
            qual_q <= 1'b1;
            cnt_q  <= '0;
          end
        end
        RX_DATA: if (!bit_end_d) cnt_q <= cnt_q + 1'b1;
        else begin
          cnt_q <= '0;
          if (bit_q != 4'd8) begin
            rx_byte_q <= {rx_s2_q, rx_byte_q[7:1]};
            bit_q     <= bit_q + 1'b1;
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rx_s2_q ? rx_byte_q : 8'h00;
            rsp_err_q   <= !rx_s2_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign req_ready = state_q == IDLE;
  assign busy_out  = state_q != IDLE;
  assign tx_out    = tx_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_uart_reg_master.sv
// tb_uart_reg_master: scoreboard bench for uart_reg_master with a frame decoder on tx and a slave reply driver on rx.
module tb_uart_reg_master;
  localparam int CPB = 8;
  localparam int TMO = 200;
  typedef struct {logic [7:0] d; logic e; int c;} rsp_t;
  typedef struct {logic [7:0] d; int c;} fr_t;
  logic       clk = 0, rst_in = 1, req_valid = 0, req_write = 0, rx_in = 1;
  logic [2:0] req_addr = 0;
  logic [7:0] req_wdata = 0;
  logic       req_ready, rsp_valid, rsp_err, busy_out, tx_out;
  logic [7:0] rsp_rdata;
  int         cyc = 0, n_chk = 0, n_fail = 0, acc;
  rsp_t       exp_rsp[$];
  fr_t        exp_fr[$];

  uart_reg_master #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
    .clk_in(clk), .rst_in(rst_in), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy_out(busy_out), .tx_out(tx_out), .rx_in(rx_in));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_rsp(input logic [7:0] d, input logic e, input int c);
    rsp_t r;
    r.d = d; r.e = e; r.c = c;
    exp_rsp.push_back(r);
  endtask

  task automatic push_fr(input logic [7:0] d, input int c);
    fr_t f;
    f.d = d; f.c = c;
    exp_fr.push_back(f);
  endtask

  task automatic do_req(input logic w, input logic [2:0] a, input logic [7:0] d, output int t);
    for (int i = 0; i < 1000 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("req_ready_wait", req_ready, 1);
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1;
    t = cyc;
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_in = f[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx_in = 1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && (exp_rsp.size() != 0 || exp_fr.size() != 0); i++) @(posedge clk);
    chk("drain_pending", exp_rsp.size() + exp_fr.size(), 0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic wait_mon(input int n, inout bit ab);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (rst_in) ab = 1;
    end
  endtask

  // response scoreboard
  initial begin
    bit prev = 0;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (prev) chk("ready_after_rsp", req_ready, 1);
      prev = 0;
      if (!rst_in && rsp_valid === 1'b1) begin
        prev = 1;
        chk("ready_during_rsp", req_ready, 0);
        if (exp_rsp.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
        else begin
          r = exp_rsp.pop_front();
          chk("rsp_rdata", rsp_rdata, r.d);
          chk("rsp_err", rsp_err, r.e);
          if (r.c >= 0) chk("rsp_cycle", cyc, r.c);
        end
      end
    end
  end

  // tx frame decoder, mid-bit sampling; frames cut by reset are discarded
  initial begin
    bit ab;
    int s;
    logic [7:0] b;
    logic st, sp;
    fr_t f;
    forever begin
      @(negedge clk);
      if (tx_out === 1'b0 && !rst_in) begin
        s = cyc; ab = 0;
        wait_mon(CPB / 2, ab);
        st = tx_out;
        for (int i = 0; i < 8; i++) begin
          wait_mon(CPB, ab);
          b[i] = tx_out;
        end
        wait_mon(CPB, ab);
        sp = tx_out;
        if (!ab) begin
          if (exp_fr.size() == 0) chk("unexpected_frame", {24'h0, b}, 32'hFFFF_FFFF);
          else begin
            f = exp_fr.pop_front();
            chk("frame_byte", b, f.d);
            chk("frame_start_cycle", s, f.c);
            chk("frame_start_bit", st, 0);
            chk("frame_stop_bit", sp, 1);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_in = 0;
    @(negedge clk);
    chk("rst_tx_out", tx_out, 1);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy_out, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    @(posedge clk); #1;
    // write addr 3 data 0x5A
    do_req(1, 3'd3, 8'h5A, acc);
    push_fr(8'h03, acc + 1);
    push_fr(8'h5A, acc + 1 + 10 * CPB);
    push_rsp(8'h00, 0, acc + 20 * CPB + 1);
    chk("busy_after_accept", busy_out, 1);
    drain();
    // read addr 1, reply 0x01 twenty cycles after command stop bit
    do_req(0, 3'd1, 8'h00, acc);
    push_fr(8'h81, acc + 1);
    push_rsp(8'h01, 0, -1);
    repeat (10 * CPB + 19) @(posedge clk);
    #1;
    chk("read_ready_low", req_ready, 0);
    chk("read_busy", busy_out, 1);
    send_frame(8'h01, 1);
    drain();
    // read addr 5, no reply, short glitch before timeout
    do_req(0, 3'd5, 8'h00, acc);
    push_fr(8'h85, acc + 1);
    push_rsp(8'h00, 1, acc + 10 * CPB + 1 + TMO);
    repeat (149) @(posedge clk);
    #1 rx_in = 0;
    repeat (3) @(posedge clk);
    #1 rx_in = 1;
    drain();
    // read addr 2, reply 0xA5 with bad stop bit
    do_req(0, 3'd2, 8'h00, acc);
    push_fr(8'h82, acc + 1);
    push_rsp(8'h00, 1, -1);
    repeat (10 * CPB + 19) @(posedge clk);
    #1;
    send_frame(8'hA5, 0);
    drain();
    // read addr 6, reply 0xA5 with good stop bit
    do_req(0, 3'd6, 8'h00, acc);
    push_fr(8'h86, acc + 1);
    push_rsp(8'hA5, 0, -1);
    repeat (10 * CPB + 9) @(posedge clk);
    #1;
    send_frame(8'hA5, 1);
    drain();
    // write addr 6 data 0xC3 with a stray request during TX_DATA
    do_req(1, 3'd6, 8'hC3, acc);
    push_fr(8'h06, acc + 1);
    push_fr(8'hC3, acc + 1 + 10 * CPB);
    push_rsp(8'h00, 0, acc + 20 * CPB + 1);
    repeat (99) @(posedge clk);
    #1 req_write = 0; req_addr = 3'd7; req_valid = 1;
    repeat (5) @(posedge clk);
    #1 req_valid = 0;
    drain();
    // reset during the command frame while tx is low
    do_req(1, 3'd4, 8'h11, acc);
    repeat (39) @(posedge clk);
    #1;
    chk("tx_before_rst", tx_out, 0);
    rst_in = 1;
    @(posedge clk); #1;
    rst_in = 0;
    @(negedge clk);
    chk("tx_after_rst", tx_out, 1);
    chk("ready_after_rst", req_ready, 1);
    chk("busy_after_rst", busy_out, 0);
    repeat (200) @(posedge clk);
    #1;
    // new write after reset
    do_req(1, 3'd2, 8'hF0, acc);
    push_fr(8'h02, acc + 1);
    push_fr(8'hF0, acc + 1 + 10 * CPB);
    push_rsp(8'h00, 0, acc + 20 * CPB + 1);
    drain();
    repeat (20) @(posedge clk);
    chk("final_rsp_queue", exp_rsp.size(), 0);
    chk("final_frame_queue", exp_fr.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
